// File: rtl/econet_pkg.sv
// Shared Econet definitions: receiver state encoding, framing constants and
// the bit-serial CRC-16 step used by both the transmitter and the receiver.
package econet_pkg;

    typedef enum logic [1:0] {
        HUNT     = 2'd0,
        SYNC     = 2'd1,
        IN_FRAME = 2'd2
    } rx_state_t;

    localparam logic [7:0]  FLAG       = 8'h7E;
    localparam logic [15:0] CRC_PRESET = 16'hFFFF;
    localparam int unsigned CRC_TAP_A  = 5;
    localparam int unsigned CRC_TAP_B  = 12;

    // x^16+x^12+x^5+1, one bit per call, feedback from the top bit
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
        logic        fb;
        logic [15:0] n;
        fb = b ^ crc[15];
        n = {crc[14:0], fb};
        n[CRC_TAP_A] = crc[CRC_TAP_A - 1] ^ fb;
        n[CRC_TAP_B] = crc[CRC_TAP_B - 1] ^ fb;
        return n;
    endfunction

endpackage

// File: rtl/econet_rx_deframer_bitclass.sv
// Raw line bit classifier: consecutive-ones counter with flag, abort,
// stuffed-zero and idle detection.
module econet_rx_bitclass #(
    parameter int unsigned IDLE_ONES = 15
) (
    input  logic netclk,
    input  logic reset,
    input  logic rxdata,
    output logic append_valid,
    output logic append_bit,
    output logic flag_evt,
    output logic abort_evt,
    output logic line_idle
);
    localparam logic [4:0] IDLE_CNT = 5'(IDLE_ONES);

    logic [4:0] ones;
    logic [4:0] ones_inc;

    always_comb begin
        ones_inc     = (ones == 5'd31) ? ones : ones + 5'd1;
        append_bit   = rxdata;
        append_valid = rxdata ? (ones_inc <= 5'd5) : (ones < 5'd5);
        flag_evt     = !rxdata && (ones == 5'd6);
        abort_evt    = rxdata && (ones_inc == 5'd7);
    end

    always_ff @(posedge netclk or posedge reset) begin
        if (reset) begin
            ones      <= '0;
            line_idle <= 1'b0;
        end else if (rxdata) begin
            ones <= ones_inc;
            if (ones_inc == IDLE_CNT)
                line_idle <= 1'b1;
        end else begin
            ones      <= '0;
            line_idle <= 1'b0;
        end
    end

endmodule

// File: rtl/econet_rx_deframer.sv
// Econet/HDLC receive deframer: lookahead and FCS delay lines in front of the
// CRC checker and LSB-first byte assembler, with HUNT/SYNC/IN_FRAME control.
module econet_rx_deframer
    import econet_pkg::*;
#(
    parameter int unsigned IDLE_ONES = 15
) (
    input  logic       netclk,
    input  logic       reset,
    input  logic       rxdata,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       sof,
    output logic       frame_end,
    output logic       crc_ok,
    output logic       frame_abort,
    output logic       line_idle,
    output logic       in_frame
);
    logic append_valid, append_bit, flag_evt, abort_evt;

    econet_rx_bitclass #(.IDLE_ONES(IDLE_ONES)) u_bitclass (
        .netclk       (netclk),
        .reset        (reset),
        .rxdata       (rxdata),
        .append_valid (append_valid),
        .append_bit   (append_bit),
        .flag_evt     (flag_evt),
        .abort_evt    (abort_evt),
        .line_idle    (line_idle)
    );

    rx_state_t   state;
    logic [5:0]  la;
    logic [2:0]  la_cnt;
    logic [15:0] fcs;
    logic [4:0]  fcs_cnt;
    logic [15:0] crc;
    logic [7:0]  shreg;
    logic [2:0]  bit_cnt;
    logic        first_byte;
    logic        byte_seen;

    logic push, flush, la_full, fcs_full, la_out_valid, fcs_out_valid;

    always_comb begin
        push          = append_valid && (state != HUNT);
        flush         = flag_evt || (abort_evt && (state != HUNT));
        la_full       = (la_cnt == 3'd6);
        fcs_full      = (fcs_cnt == 5'd16);
        la_out_valid  = push && la_full;
        fcs_out_valid = la_out_valid && fcs_full;
    end

    assign in_frame = (state == IN_FRAME);

    always_ff @(posedge netclk or posedge reset) begin
        if (reset) begin
            state       <= HUNT;
            la          <= '0;
            la_cnt      <= '0;
            fcs         <= '0;
            fcs_cnt     <= '0;
            crc         <= CRC_PRESET;
            shreg       <= '0;
            bit_cnt     <= '0;
            first_byte  <= 1'b1;
            byte_seen   <= 1'b0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            sof         <= 1'b0;
            frame_end   <= 1'b0;
            crc_ok      <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            data_valid  <= 1'b0;
            sof         <= 1'b0;
            frame_end   <= 1'b0;
            crc_ok      <= 1'b0;
            frame_abort <= 1'b0;

            if (flush) begin
                la_cnt     <= '0;
                fcs_cnt    <= '0;
                crc        <= CRC_PRESET;
                bit_cnt    <= '0;
                first_byte <= 1'b1;
                byte_seen  <= 1'b0;
            end else if (push) begin
                la <= {append_bit, la[5:1]};
                if (!la_full)
                    la_cnt <= la_cnt + 3'd1;
                if (la_out_valid) begin
                    fcs <= {la[0], fcs[15:1]};
                    if (!fcs_full)
                        fcs_cnt <= fcs_cnt + 5'd1;
                end
                // Only bits that have cleared both delay lines are payload
                if (fcs_out_valid) begin
                    crc     <= crc16_step(crc, fcs[0]);
                    shreg   <= {fcs[0], shreg[7:1]};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        data_out   <= {fcs[0], shreg[7:1]};
                        data_valid <= 1'b1;
                        sof        <= first_byte;
                        first_byte <= 1'b0;
                        byte_seen  <= 1'b1;
                    end
                end
            end

            case (state)
                HUNT: begin
                    if (flag_evt)
                        state <= SYNC;
                end
                SYNC: begin
                    if (abort_evt)
                        state <= HUNT;
                    else if (push)
                        state <= IN_FRAME;
                end
                IN_FRAME: begin
                    if (abort_evt) begin
                        frame_abort <= 1'b1;
                        state       <= HUNT;
                    end else if (flag_evt) begin
                        if (fcs_full) begin
                            frame_end <= 1'b1;
                            crc_ok    <= (bit_cnt == 3'd0) && byte_seen && (fcs == ~crc);
                        end
                        state <= SYNC;
                    end
                end
                default: state <= HUNT;
            endcase
        end
    end

endmodule

// File: tb/tb_econet_rx_deframer.sv
// Self-checking bench for econet_rx_deframer: frames are built with a local
// stuffing/CRC model, expected bytes and CRC verdicts go through a scoreboard.
module tb_econet_rx_deframer;
    logic       netclk = 1'b0;
    logic       reset  = 1'b1;
    logic       rxdata = 1'b1;
    logic [7:0] data_out;
    logic       data_valid, sof, frame_end, crc_ok, frame_abort, line_idle, in_frame;

    econet_rx_deframer #(.IDLE_ONES(15)) dut (
        .netclk      (netclk),
        .reset       (reset),
        .rxdata      (rxdata),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .sof         (sof),
        .frame_end   (frame_end),
        .crc_ok      (crc_ok),
        .frame_abort (frame_abort),
        .line_idle   (line_idle),
        .in_frame    (in_frame)
    );

    always #5 netclk = ~netclk;

    int n_tests = 0;
    int n_fail  = 0;
    int dv_cnt  = 0;
    int fe_cnt  = 0;
    int fa_cnt  = 0;

    logic [8:0] exp_q[$];     // {sof, byte}
    logic       exp_crc_q[$];
    logic [7:0] dq[$];
    bit         tx_q[$];
    int         tx_ones;

    // Scoreboard consumer, sampled away from the active edge
    always @(negedge netclk) begin
        if (!reset) begin
            if (data_valid) begin
                dv_cnt++;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_byte: got %h sof=%b, expected none", data_out, sof);
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    if ({sof, data_out} !== e) begin
                        n_fail++;
                        $display("FAIL byte: got sof=%b data=%h, expected sof=%b data=%h",
                                 sof, data_out, e[8], e[7:0]);
                    end
                end
            end
            if (frame_end) begin
                fe_cnt++;
                n_tests++;
                if (exp_crc_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_frame_end: got crc_ok=%b, expected no frame_end", crc_ok);
                end else begin
                    logic ec;
                    ec = exp_crc_q.pop_front();
                    if (crc_ok !== ec) begin
                        n_fail++;
                        $display("FAIL crc_ok: got %b expected %b", crc_ok, ec);
                    end
                end
            end
            if (frame_abort)
                fa_cnt++;
        end
    end

    task automatic send_bit(input bit b);
        rxdata = b;
        @(posedge netclk);
        #1;
    endtask

    task automatic send_q();
        while (tx_q.size() > 0)
            send_bit(tx_q.pop_front());
        @(negedge netclk);
        #1;
    endtask

    task automatic q_flag();
        tx_q.push_back(1'b0);
        repeat (6) tx_q.push_back(1'b1);
        tx_q.push_back(1'b0);
        tx_ones = 0;
    endtask

    task automatic q_bit(input bit b);
        tx_q.push_back(b);
        if (b) begin
            tx_ones++;
            if (tx_ones == 5) begin
                tx_q.push_back(1'b0);
                tx_ones = 0;
            end
        end else begin
            tx_ones = 0;
        end
    endtask

    // Queues flag, dq payload, FCS (~crc, LSB first), flag; flip>=0 corrupts one FCS bit
    task automatic q_frame(input int flip);
        logic [15:0] c;
        logic [15:0] f;
        logic [7:0]  d;
        bit          b;
        c = 16'hFFFF;
        q_flag();
        for (int j = 0; j < dq.size(); j++) begin
            d = dq[j];
            exp_q.push_back({(j == 0), d});
            for (int i = 0; i < 8; i++) begin
                b = d[i];
                q_bit(b);
                c = (c << 1) ^ ((b ^ c[15]) ? 16'h1021 : 16'h0000);
            end
        end
        f = ~c;
        if (flip >= 0)
            f[flip] = ~f[flip];
        for (int i = 0; i < 16; i++)
            q_bit(f[i]);
        q_flag();
        exp_crc_q.push_back(flip < 0);
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        rxdata = 1'b1;
        repeat (3) @(posedge netclk);
        #1;
        n_tests++;
        if ({data_out, data_valid, sof, frame_end, crc_ok, frame_abort, line_idle, in_frame} !== 14'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {data_out, data_valid, sof, frame_end, crc_ok, frame_abort, line_idle, in_frame});
        end
        reset = 1'b0;
        repeat (2) send_bit(1'b1);
    endtask

    task automatic check_frame(input string name, input int dv0, input int fe0, input int fa0, input int ndv);
        n_tests++;
        if (dv_cnt - dv0 != ndv || fe_cnt - fe0 != 1 || fa_cnt != fa0) begin
            n_fail++;
            $display("FAIL %s_counts: got bytes=%0d ends=%0d aborts=%0d, expected %0d 1 0",
                     name, dv_cnt - dv0, fe_cnt - fe0, fa_cnt - fa0, ndv);
        end
        n_tests++;
        if (exp_q.size() != 0 || exp_crc_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_pending: got %0d bytes %0d ends outstanding, expected 0 0",
                     name, exp_q.size(), exp_crc_q.size());
        end
    endtask

    task automatic test_basic();
        int dv0 = dv_cnt, fe0 = fe_cnt, fa0 = fa_cnt;
        dq = {8'h12, 8'h34};
        q_frame(-1);
        send_q();
        check_frame("basic", dv0, fe0, fa0, 2);
    endtask

    task automatic test_stuffing();
        int dv0 = dv_cnt, fe0 = fe_cnt, fa0 = fa_cnt;
        dq = {8'hFF, 8'h7E};
        q_frame(-1);
        send_q();
        check_frame("stuffing", dv0, fe0, fa0, 2);
    endtask

    task automatic test_bad_fcs();
        int dv0 = dv_cnt, fe0 = fe_cnt, fa0 = fa_cnt;
        dq = {8'h12, 8'h34};
        q_frame(3);
        send_q();
        check_frame("bad_fcs", dv0, fe0, fa0, 2);
    endtask

    task automatic test_abort_idle();
        int dv0 = dv_cnt, fe0 = fe_cnt, fa0 = fa_cnt;
        q_flag();
        for (int i = 0; i < 8; i++)
            q_bit(i[0]);          // AA, LSB first: ends with a 1
        send_q();
        repeat (13) send_bit(1'b1);   // 14 consecutive ones on the line
        n_tests++;
        if (line_idle !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_early: got %b expected 0", line_idle);
        end
        n_tests++;
        if (fa_cnt - fa0 != 1 || fe_cnt != fe0 || dv_cnt != dv0) begin
            n_fail++;
            $display("FAIL abort_counts: got aborts=%0d ends=%0d bytes=%0d, expected 1 0 0",
                     fa_cnt - fa0, fe_cnt - fe0, dv_cnt - dv0);
        end
        send_bit(1'b1);               // 15th
        n_tests++;
        if (line_idle !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_set: got %b expected 1", line_idle);
        end
        send_bit(1'b0);
        n_tests++;
        if (line_idle !== 1'b0 || in_frame !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_clear: got idle=%b in_frame=%b expected 0 0", line_idle, in_frame);
        end
    endtask

    task automatic test_runt_shared();
        int dv0 = dv_cnt, fe0 = fe_cnt, fa0 = fa_cnt;
        q_flag();
        for (int i = 0; i < 12; i++)
            q_bit(~i[0]);
        q_flag();
        send_q();
        n_tests++;
        if (dv_cnt != dv0 || fe_cnt != fe0 || fa_cnt != fa0 || in_frame !== 1'b0) begin
            n_fail++;
            $display("FAIL runt: got bytes=%0d ends=%0d aborts=%0d in_frame=%b, expected 0 0 0 0",
                     dv_cnt - dv0, fe_cnt - fe0, fa_cnt - fa0, in_frame);
        end
        q_flag();
        repeat (2) begin
            repeat (6) tx_q.push_back(1'b1);
            tx_q.push_back(1'b0);
        end
        send_q();
        n_tests++;
        if (dv_cnt != dv0 || fe_cnt != fe0 || fa_cnt != fa0 || in_frame !== 1'b0) begin
            n_fail++;
            $display("FAIL shared_flags: got bytes=%0d ends=%0d aborts=%0d in_frame=%b, expected 0 0 0 0",
                     dv_cnt - dv0, fe_cnt - fe0, fa_cnt - fa0, in_frame);
        end
    endtask

    task automatic test_reset_mid_frame();
        int dv0 = dv_cnt, fe0 = fe_cnt;
        int budget = 0;
        dq = {8'h12, 8'h34, 8'h56, 8'h78};
        q_frame(-1);
        while (dv_cnt - dv0 < 2 && tx_q.size() > 0 && budget < 500) begin
            send_bit(tx_q.pop_front());
            budget++;
        end
        n_tests++;
        if (dv_cnt - dv0 != 2 || in_frame !== 1'b1) begin
            n_fail++;
            $display("FAIL midframe_reach: got bytes=%0d in_frame=%b, expected 2 1", dv_cnt - dv0, in_frame);
        end
        tx_q.delete();
        reset = 1'b1;
        #1;
        n_tests++;
        if ({data_out, data_valid, sof, frame_end, crc_ok, frame_abort, line_idle, in_frame} !== 14'h0) begin
            n_fail++;
            $display("FAIL midframe_reset: got %h expected 0",
                     {data_out, data_valid, sof, frame_end, crc_ok, frame_abort, line_idle, in_frame});
        end
        @(posedge netclk);
        #1;
        reset = 1'b0;
        n_tests++;
        if (exp_q.size() != 2 || exp_crc_q.size() != 1 || fe_cnt != fe0) begin
            n_fail++;
            $display("FAIL midframe_pending: got %0d bytes %0d ends left, ends seen %0d, expected 2 1 0",
                     exp_q.size(), exp_crc_q.size(), fe_cnt - fe0);
        end
        exp_q.delete();
        exp_crc_q.delete();
        send_bit(1'b1);
        dv0 = dv_cnt;
        fe0 = fe_cnt;
        dq = {8'h12, 8'h34};
        q_frame(-1);
        send_q();
        check_frame("recover", dv0, fe0, fa_cnt, 2);
    endtask

    initial begin
        tx_ones = 0;
        test_reset();
        test_basic();
        test_stuffing();
        test_bad_fcs();
        test_abort_idle();
        test_runt_shared();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no completion, expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/econet_rx_deframer.md
Name: econet_rx_deframer

Overview:
- Bit-level HDLC/Econet receiver. It is the receive-side counterpart of the team's frame transmitter.
- Takes the recovered line bit `rxdata`, sampled once per `netclk` rising edge.
- Functions: flag detection, zero-bit deletion, abort and line-idle detection, LSB-first byte assembly, CRC-16 (x^16+x^12+x^5+1, preset FFFF) check of the trailing 16-bit FCS.
- Delivers bytes and frame status to the Econet receive FIFO / host interface.

Parameters:
IDLE_ONES, 15, number of consecutive 1s after which line_idle asserts.

Ports:
netclk  in  1  bit clock; rxdata sampled on rising edge
reset  in  1  asynchronous, active-high
rxdata  in  1  serial line bit
data_out  out  8  last assembled byte, LSB received first
data_valid  out  1  one-cycle pulse; data_out valid this cycle
sof  out  1  qualifies data_valid: first byte of frame
frame_end  out  1  one-cycle pulse on closing flag of a non-runt frame
crc_ok  out  1  valid with frame_end: FCS matched and length byte-aligned
frame_abort  out  1  one-cycle pulse: abort (>=7 ones) while IN_FRAME
line_idle  out  1  level: >= IDLE_ONES consecutive 1s seen
in_frame  out  1  level: state == IN_FRAME

Behaviour:
- Reset: all outputs 0, data_out=00, state HUNT, ones count 0, crc=FFFF, all pipelines empty.

Raw bit classification, every cycle (ones = count of consecutive 1s before this bit, saturating at 31):
- rxdata=1: ones++. Append the bit iff the new count is <=5. At new count==7, abort event. At new count==IDLE_ONES, set line_idle.
- rxdata=0 with ones==5: stuffed bit; drop it.
- rxdata=0 with ones==6: flag event; bit not appended.
- rxdata=0 with ones>=7: end of abort/idle; not appended.
- rxdata=0 with ones<5: append 0.
- Any 0 clears ones and line_idle.

Pipeline for appended bits, in order (occupancy-counted):
- 6-bit lookahead line.
- Then 16-bit FCS line, shift {b, fcs[15:1]}.
- Then CRC + byte assembler.
- A bit leaves a line only when pushing into it would exceed its capacity.
- The lookahead absorbs the 0+11111 prefix of a closing flag.

CRC update on each bit b leaving the FCS line (c = crc):
- n0 = b^c15
- n5 = c4^b^c15
- n12 = c11^b^c15
- every other bit: n[i] = c[i-1]

Byte assembler:
- Shift byte <= {b, byte[7:1]}, bit counter mod 8.
- On the 8th bit: data_out updates and data_valid pulses the next cycle. sof=1 if this is the first byte since the flag.

States and transitions:
- HUNT:
  - flag -> SYNC.
  - No output activity.
- SYNC:
  - First appended bit -> IN_FRAME.
  - flag stays SYNC (back-to-back or shared-zero flags).
  - abort -> HUNT, no pulse.
- IN_FRAME, on flag:
  - If FCS line full: frame_end pulse. crc_ok=1 iff bit counter==0, >=1 byte emitted, and fcs == ~crc.
  - If FCS line not full: runt; silently dropped, no frame_end.
  - Both cases: flush lookahead and FCS line, crc=FFFF, bit counter 0, next state SYNC.
- IN_FRAME, on abort: frame_abort pulse, flush as above, next state HUNT.

Timing and boundary rules:
- Latency: a data bit reaches the assembler 22 appended bits after it is received. frame_end/frame_abort pulse the cycle after the flag/abort bit.
- A flag/abort cycle appends nothing, so data_valid and frame_end never coincide.
- Shared zero between flags (0111111011111 10) is handled; the inter-flag lookahead never reaches the FCS line.
- Reset mid-frame: immediate return to reset state; no frame_end.

Decomposition:
- Shared package econet_pkg:
  - state encoding (HUNT/SYNC/IN_FRAME)
  - FLAG=8'h7E
  - CRC_PRESET=16'hFFFF
  - CRC tap positions
  - crc16_step function, shared with the transmitter
- One natural sub-module: econet_rx_bitclass. It holds the ones counter and flag/abort/stuff/idle classification and outputs append_valid, append_bit, flag_evt, abort_evt, line_idle.

Test Plan:
- Flag, bytes 12 34, bench-model FCS, flag -> data_valid 12 (sof=1), then 34 (sof=0); frame_end=1, crc_ok=1; no frame_abort.
- Frame with byte FF (raw 11111 0 111) and 7E payload, correct FCS -> data_out FF then 7E, crc_ok=1; stuffed zeros never seen in data.
- Same frame as the first scenario with one FCS bit inverted -> both bytes delivered; frame_end=1, crc_ok=0.
- Flag, AA, then eight 1s -> frame_abort single pulse, no frame_end; 15th consecutive 1 -> line_idle=1; next 0 -> line_idle=0.
- Flag, 12 raw bits, flag -> no data_valid, no frame_end (runt). Then 7E 7E 7E with shared zeros -> stays SYNC, no outputs.
- Assert reset for 1 cycle after the 2nd byte of a valid frame -> all outputs 0 immediately. A following complete frame 12 34 decodes with crc_ok=1.
